// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : Y86 5-stage stall/bubble/CC control with RET-drain and halt FSM.
// Optional build macro: PIPE_PERF_CNT_EN (load-use / mispredict counters).
// Revision  : 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl #(
   parameter int         RET_DRAIN_CYCLES = 3,
   parameter logic [7:0] RNONE            = 8'h0F,
   parameter int         CNT_W            = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       D_icode_i,
   input  logic [7:0]       d_srcA_i,
   input  logic [7:0]       d_srcB_i,
   input  logic [7:0]       E_icode_i,
   input  logic [7:0]       E_dstM_i,
   input  logic             e_Cnd_i,
   input  logic             halt_i,
   input  logic             err_i,
   output logic             F_stall_o,
   output logic             D_stall_o,
   output logic             D_bubble_o,
   output logic             E_bubble_o,
   output logic             M_bubble_o,
   output logic             W_stall_o,
   output logic             set_cc_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] squash_cnt_o
);

   localparam logic [7:0] C_MRMOVL = 8'h05;
   localparam logic [7:0] C_OPL    = 8'h06;
   localparam logic [7:0] C_JXX    = 8'h07;
   localparam logic [7:0] C_RET    = 8'h09;
   localparam logic [7:0] C_POPL   = 8'h0B;

   localparam int              RC_W       = $clog2(RET_DRAIN_CYCLES + 1);
   localparam logic [RC_W-1:0] C_RET_LOAD = RC_W'(RET_DRAIN_CYCLES - 1);
   localparam logic [RC_W-1:0] C_RET_ONE  = RC_W'(1);

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_RET_DRAIN = 2'd1,
      ST_HALTED    = 2'd2,
      ST_ERROR     = 2'd3
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [RC_W-1:0] r_ret_cnt, w_ret_cnt_nxt;
   logic            w_lu, w_mp, w_rt;

   assign w_lu = ((E_icode_i == C_MRMOVL) || (E_icode_i == C_POPL)) &&
                 (E_dstM_i != RNONE) &&
                 ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
   assign w_mp = (E_icode_i == C_JXX) && !e_Cnd_i;
   assign w_rt = (D_icode_i == C_RET);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_RUN;
         r_ret_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_ret_cnt <= w_ret_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_ret_cnt_nxt = r_ret_cnt;
      F_stall_o     = 1'b0;
      D_stall_o     = 1'b0;
      D_bubble_o    = 1'b0;
      E_bubble_o    = 1'b0;
      M_bubble_o    = 1'b0;
      W_stall_o     = 1'b0;
      set_cc_o      = 1'b0;
      case (r_state)
         ST_RUN, ST_RET_DRAIN: begin
            set_cc_o = (E_icode_i == C_OPL) && !halt_i && !err_i;
            if (halt_i || err_i) begin
               F_stall_o   = 1'b1;
               D_stall_o   = 1'b1;
               W_stall_o   = 1'b1;
               M_bubble_o  = 1'b1;
               w_state_nxt = err_i ? ST_ERROR : ST_HALTED;
            end else if (r_state == ST_RET_DRAIN) begin
               // D holds the injected bubble here, so hazards on it are moot
               F_stall_o     = 1'b1;
               D_bubble_o    = 1'b1;
               w_ret_cnt_nxt = r_ret_cnt - C_RET_ONE;
               if (r_ret_cnt == C_RET_ONE)
                  w_state_nxt = ST_RUN;
            end else if (w_mp) begin
               D_bubble_o = 1'b1;
               E_bubble_o = 1'b1;
            end else if (w_lu) begin
               F_stall_o  = 1'b1;
               D_stall_o  = 1'b1;
               E_bubble_o = 1'b1;
            end else if (w_rt) begin
               F_stall_o     = 1'b1;
               D_bubble_o    = 1'b1;
               w_ret_cnt_nxt = C_RET_LOAD;
               w_state_nxt   = ST_RET_DRAIN;
            end
         end
         default: begin
            F_stall_o  = 1'b1;
            D_stall_o  = 1'b1;
            W_stall_o  = 1'b1;
            M_bubble_o = 1'b1;
         end
      endcase
      // Async reset overrides everything so the pipe is flushed while held
      if (!rst) begin
         F_stall_o  = 1'b0;
         D_stall_o  = 1'b0;
         D_bubble_o = 1'b1;
         E_bubble_o = 1'b1;
         M_bubble_o = 1'b1;
         W_stall_o  = 1'b0;
         set_cc_o   = 1'b0;
      end
   end

   assign state_o = r_state;

`ifdef PIPE_PERF_CNT_EN
   logic             w_lu_run, w_mp_run;
   logic [CNT_W-1:0] r_stall_cnt, r_squash_cnt;

   assign w_lu_run = (r_state == ST_RUN) && !halt_i && !err_i && !w_mp && w_lu;
   assign w_mp_run = (r_state == ST_RUN) && !halt_i && !err_i && w_mp;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt  <= '0;
         r_squash_cnt <= '0;
      end else begin
         if (w_lu_run && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_mp_run && (r_squash_cnt != '1))
            r_squash_cnt <= r_squash_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt_o  = r_stall_cnt;
   assign squash_cnt_o = r_squash_cnt;
`else
   assign stall_cnt_o  = '0;
   assign squash_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// tb_pipe_ctrl : scoreboard bench for pipe_ctrl hazard, drain and halt control.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

   localparam logic [7:0] NOP    = 8'h01;
   localparam logic [7:0] MRMOVL = 8'h05;
   localparam logic [7:0] OPL    = 8'h06;
   localparam logic [7:0] JXX    = 8'h07;
   localparam logic [7:0] RET    = 8'h09;
   localparam logic [7:0] POPL   = 8'h0B;
   localparam logic [7:0] RN     = 8'h0F;
`ifdef PIPE_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  D_icode = NOP, d_srcA = RN, d_srcB = RN, E_icode = NOP, E_dstM = RN;
   logic        e_Cnd = 1'b0, halt = 1'b0, err = 1'b0;
   logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
   logic [1:0]  state;
   logic [31:0] stall_cnt, squash_cnt;

   typedef struct {
      logic [6:0]  ctl;
      logic [1:0]  st;
      logic [31:0] sc;
      logic [31:0] qc;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   pipe_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .D_icode_i    (D_icode),
      .d_srcA_i     (d_srcA),
      .d_srcB_i     (d_srcB),
      .E_icode_i    (E_icode),
      .E_dstM_i     (E_dstM),
      .e_Cnd_i      (e_Cnd),
      .halt_i       (halt),
      .err_i        (err),
      .F_stall_o    (F_stall),
      .D_stall_o    (D_stall),
      .D_bubble_o   (D_bubble),
      .E_bubble_o   (E_bubble),
      .M_bubble_o   (M_bubble),
      .W_stall_o    (W_stall),
      .set_cc_o     (set_cc),
      .state_o      (state),
      .stall_cnt_o  (stall_cnt),
      .squash_cnt_o (squash_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pc(input int n);
      return PERF ? 32'(n) : 32'd0;
   endfunction

   // Ctl vector order: F_stall D_stall D_bubble E_bubble M_bubble W_stall set_cc
   task automatic step(input string tag, input logic r,
                       input logic [7:0] di, input logic [7:0] sa, input logic [7:0] sb,
                       input logic [7:0] ei, input logic [7:0] dm,
                       input logic c, input logic h, input logic e,
                       input logic [6:0] ectl, input logic [1:0] est,
                       input logic [31:0] esc, input logic [31:0] eqc);
      exp_t x;
      @(posedge clk);
      #1;
      rst = r; D_icode = di; d_srcA = sa; d_srcB = sb;
      E_icode = ei; E_dstM = dm; e_Cnd = c; halt = h; err = e;
      sb_q.push_back('{ctl: ectl, st: est, sc: esc, qc: eqc});
      @(negedge clk);
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         x = sb_q.pop_front();
         check({tag, "_ctl"}, 32'({F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}), 32'(x.ctl));
         check({tag, "_state"}, 32'(state), 32'(x.st));
         check({tag, "_stall_cnt"}, stall_cnt, x.sc);
         check({tag, "_squash_cnt"}, squash_cnt, x.qc);
      end
   endtask

   initial begin
      step("rst_hold",  1'b0, NOP, RN, RN,    NOP,    RN,    1'b0, 1'b0, 1'b0, 7'b0011100, 2'd0, 0, 0);
      step("rst_rel",   1'b1, NOP, RN, RN,    NOP,    RN,    1'b0, 1'b0, 1'b0, 7'b0000000, 2'd0, 0, 0);
      step("lu_mrmovl", 1'b1, NOP, RN, 8'h03, MRMOVL, 8'h03, 1'b0, 1'b0, 1'b0, 7'b1101000, 2'd0, 0, 0);
      step("lu_rnone",  1'b1, NOP, RN, 8'h03, MRMOVL, RN,    1'b0, 1'b0, 1'b0, 7'b0000000, 2'd0, pc(1), 0);
      step("lu_popl",   1'b1, RET, 8'h02, RN, POPL,   8'h02, 1'b0, 1'b0, 1'b0, 7'b1101000, 2'd0, pc(1), 0);
      step("lu_after",  1'b1, NOP, RN, RN,    NOP,    RN,    1'b0, 1'b0, 1'b0, 7'b0000000, 2'd0, pc(2), 0);
      step("mp_ret",    1'b1, RET, RN, RN,    JXX,    RN,    1'b0, 1'b0, 1'b0, 7'b0011000, 2'd0, pc(2), 0);
      step("mp_after",  1'b1, NOP, RN, RN,    NOP,    RN,    1'b0, 1'b0, 1'b0, 7'b0000000, 2'd0, pc(2), pc(1));
      step("jxx_taken", 1'b1, NOP, RN, RN,    JXX,    RN,    1'b1, 1'b0, 1'b0, 7'b0000000, 2'd0, pc(2), pc(1));
      step("ret_det",   1'b1, RET, RN, RN,    NOP,    RN,    1'b0, 1'b0, 1'b0, 7'b1010000, 2'd0, pc(2), pc(1));
      step("ret_d1",    1'b1, NOP, RN, RN,    OPL,    RN,    1'b0, 1'b0, 1'b0, 7'b1010001, 2'd1, pc(2), pc(1));
      step("ret_d2",    1'b1, NOP, RN, RN,    NOP,    RN,    1'b0, 1'b0, 1'b0, 7'b1010000, 2'd1, pc(2), pc(1));
      step("ret_done",  1'b1, NOP, RN, RN,    NOP,    RN,    1'b0, 1'b0, 1'b0, 7'b0000000, 2'd0, pc(2), pc(1));
      step("cc_opl",    1'b1, NOP, RN, RN,    OPL,    RN,    1'b0, 1'b0, 1'b0, 7'b0000001, 2'd0, pc(2), pc(1));
      step("ret_det2",  1'b1, RET, RN, RN,    NOP,    RN,    1'b0, 1'b0, 1'b0, 7'b1010000, 2'd0, pc(2), pc(1));
      step("halt_drn",  1'b1, NOP, RN, RN,    NOP,    RN,    1'b0, 1'b1, 1'b0, 7'b1100110, 2'd1, pc(2), pc(1));
      step("halt_stk",  1'b1, NOP, RN, RN,    NOP,    RN,    1'b0, 1'b0, 1'b0, 7'b1100110, 2'd2, pc(2), pc(1));
      step("halt_cc",   1'b1, NOP, RN, RN,    OPL,    RN,    1'b0, 1'b0, 1'b0, 7'b1100110, 2'd2, pc(2), pc(1));
      step("rst_halt",  1'b0, NOP, RN, RN,    NOP,    RN,    1'b0, 1'b0, 1'b0, 7'b0011100, 2'd0, 0, 0);
      step("ret_det3",  1'b1, RET, RN, RN,    NOP,    RN,    1'b0, 1'b0, 1'b0, 7'b1010000, 2'd0, 0, 0);
      step("rst_drain", 1'b0, NOP, RN, RN,    NOP,    RN,    1'b0, 1'b0, 1'b0, 7'b0011100, 2'd0, 0, 0);
      step("rst_rel2",  1'b1, NOP, RN, RN,    NOP,    RN,    1'b0, 1'b0, 1'b0, 7'b0000000, 2'd0, 0, 0);
      step("err_cc",    1'b1, NOP, RN, RN,    OPL,    RN,    1'b0, 1'b0, 1'b1, 7'b1100110, 2'd0, 0, 0);
      step("err_stk",   1'b1, NOP, RN, RN,    NOP,    RN,    1'b0, 1'b0, 1'b0, 7'b1100110, 2'd3, 0, 0);
      step("rst_err",   1'b0, NOP, RN, RN,    NOP,    RN,    1'b0, 1'b0, 1'b0, 7'b0011100, 2'd0, 0, 0);
      step("both_term", 1'b1, NOP, RN, RN,    NOP,    RN,    1'b0, 1'b1, 1'b1, 7'b1100110, 2'd0, 0, 0);
      step("both_stk",  1'b1, NOP, RN, RN,    NOP,    RN,    1'b0, 1'b0, 1'b0, 7'b1100110, 2'd3, 0, 0);
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
